// File: rtl/psram_line_cache_pkg.sv
// Shared definitions for the PSRAM line cache: line geometry, the miss
// handling FSM states and the burst command encoding.
package psram_line_cache_pkg;

    localparam int WORD_W          = 32;
    localparam int WORDS_PER_LINE  = 8;
    localparam int BEATS_PER_BURST = 4;
    localparam int BEAT_W          = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_FILL_CMD,
        ST_FILL,
        ST_FINISH
    } state_t;

    localparam logic BR_CMD_READ  = 1'b0;
    localparam logic BR_CMD_WRITE = 1'b1;

endpackage

// File: rtl/psram_line_cache_line_store.sv
// Line storage for the cache: byte-writable data array organised as
// 64-bit beats of two words each, plus the valid/dirty/tag array.
// Data reads are registered (one cycle); metadata reads are combinational
// so the hit decision can be made in the cycle the request is presented.
module cache_line_store
    import psram_line_cache_pkg::*;
#(
    parameter int IndexW = 8,
    parameter int TagW   = 11
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rd_en,
    input  logic [IndexW-1:0] i_rd_index,
    input  logic [1:0]        i_rd_beat,
    output logic [BEAT_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [IndexW-1:0] i_wr_index,
    input  logic [2:0]        i_wr_col,
    input  logic [3:0]        i_wr_mask,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic              i_fill_en,
    input  logic [IndexW-1:0] i_fill_index,
    input  logic [1:0]        i_fill_beat,
    input  logic [BEAT_W-1:0] i_fill_data,
    input  logic [IndexW-1:0] i_meta_index,
    output logic              o_meta_valid,
    output logic              o_meta_dirty,
    output logic [TagW-1:0]   o_meta_tag,
    input  logic              i_meta_we,
    input  logic [IndexW-1:0] i_meta_wr_index,
    input  logic              i_meta_valid,
    input  logic              i_meta_dirty,
    input  logic [TagW-1:0]   i_meta_tag
);

    localparam int LINES = 1 << IndexW;

    logic [WORD_W-1:0] r_data [LINES][WORDS_PER_LINE];
    logic [LINES-1:0]  r_valid;
    logic [LINES-1:0]  r_dirty;
    logic [TagW-1:0]   r_tag [LINES];

    // Data array writes: whole beats from a fill, or masked bytes of one word
    always_ff @(posedge i_clk) begin
        if (i_fill_en) begin
            r_data[i_fill_index][{i_fill_beat, 1'b0}] <= i_fill_data[WORD_W-1:0];
            r_data[i_fill_index][{i_fill_beat, 1'b1}] <= i_fill_data[BEAT_W-1:WORD_W];
        end else if (i_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wr_mask[b]) begin
                    r_data[i_wr_index][i_wr_col][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
    end

    // Registered beat read; holds its value until the next read strobe
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_data <= '0;
        end else if (i_rd_en) begin
            o_rd_data <= {r_data[i_rd_index][{i_rd_beat, 1'b1}],
                          r_data[i_rd_index][{i_rd_beat, 1'b0}]};
        end
    end

    // Valid/dirty bits, cleared by reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_meta_we) begin
            r_valid[i_meta_wr_index] <= i_meta_valid;
            r_dirty[i_meta_wr_index] <= i_meta_dirty;
        end
    end

    // Tag array; meaningless while the line is invalid, so never reset
    always_ff @(posedge i_clk) begin
        if (i_meta_we) begin
            r_tag[i_meta_wr_index] <= i_meta_tag;
        end
    end

    assign o_meta_valid = r_valid[i_meta_index];
    assign o_meta_dirty = r_dirty[i_meta_index];
    assign o_meta_tag   = r_tag[i_meta_index];

endmodule

// File: rtl/psram_line_cache.sv
// Direct-mapped, write-back, write-allocate cache between a 32-bit CPU word
// port and a 64-bit, 4-beat burst RAM. Hits finish in one cycle; misses
// evict a dirty victim, fill the line, then complete the original request.
module psram_line_cache
    import psram_line_cache_pkg::*;
#(
    parameter int LineIndexBitWidth  = 8,
    parameter int RamAddressBitWidth = 21,
    parameter int RamAddressingMode  = 3
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_enable,
    input  logic [3:0]                    i_write_enable,
    input  logic [31:0]                   i_address,
    input  logic [WORD_W-1:0]             i_data_in,
    output logic [WORD_W-1:0]             o_data_out,
    output logic                          o_data_out_ready,
    output logic                          o_busy,
    output logic                          o_br_cmd,
    output logic                          o_br_cmd_en,
    output logic [RamAddressBitWidth-1:0] o_br_addr,
    output logic [BEAT_W-1:0]             o_br_wr_data,
    output logic [7:0]                    o_br_data_mask,
    input  logic [BEAT_W-1:0]             i_br_rd_data,
    input  logic                          i_br_rd_data_valid
);

    localparam int IW   = LineIndexBitWidth;
    localparam int BA_W = RamAddressBitWidth + RamAddressingMode;
    localparam int TW   = BA_W - 5 - IW;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS_PER_BURST - 1);

    state_t            r_state, w_state_nxt;
    logic [TW-1:0]     r_tag, r_old_tag;
    logic [IW-1:0]     r_index;
    logic [2:0]        r_col;
    logic [WORD_W-1:0] r_wdata;
    logic [3:0]        r_wmask;
    logic [1:0]        r_beat;
    logic              r_dout_rdy;

    logic [2:0]        w_req_col;
    logic [IW-1:0]     w_req_index;
    logic [TW-1:0]     w_req_tag;
    logic              w_is_write, w_accept, w_hit;
    logic              w_unused_addr;

    logic              w_rd_en, w_wr_en, w_fill_en, w_meta_we;
    logic [IW-1:0]     w_rd_index, w_wr_index, w_meta_wr_index;
    logic [1:0]        w_rd_beat;
    logic [2:0]        w_wr_col;
    logic [3:0]        w_wr_mask;
    logic [WORD_W-1:0] w_wr_data;
    logic              w_meta_valid_in, w_meta_dirty_in;
    logic [TW-1:0]     w_meta_tag_in;
    logic [BEAT_W-1:0] w_rd_data;
    logic              w_meta_valid, w_meta_dirty;
    logic [TW-1:0]     w_meta_tag;

    // Line base in RAM address units: the byte base shifted right by the mode
    function automatic logic [RamAddressBitWidth-1:0] line_base(
        input logic [TW-1:0] tag,
        input logic [IW-1:0] idx
    );
        return {tag, idx, {(5 - RamAddressingMode){1'b0}}};
    endfunction

    assign w_req_col     = i_address[4:2];
    assign w_req_index   = i_address[5 +: IW];
    assign w_req_tag     = i_address[5 + IW +: TW];
    assign w_is_write    = |i_write_enable;
    assign w_accept      = i_enable && (r_state == ST_IDLE);
    assign w_hit         = w_meta_valid && (w_meta_tag == w_req_tag);
    assign w_unused_addr = ^{i_address[31:BA_W], i_address[1:0]};

    assign o_data_out       = r_col[0] ? w_rd_data[BEAT_W-1:WORD_W] : w_rd_data[WORD_W-1:0];
    assign o_data_out_ready = r_dout_rdy;
    assign o_br_data_mask   = '0;

    cache_line_store #(
        .IndexW (IW),
        .TagW   (TW)
    ) u_store (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_rd_en         (w_rd_en),
        .i_rd_index      (w_rd_index),
        .i_rd_beat       (w_rd_beat),
        .o_rd_data       (w_rd_data),
        .i_wr_en         (w_wr_en),
        .i_wr_index      (w_wr_index),
        .i_wr_col        (w_wr_col),
        .i_wr_mask       (w_wr_mask),
        .i_wr_data       (w_wr_data),
        .i_fill_en       (w_fill_en),
        .i_fill_index    (r_index),
        .i_fill_beat     (r_beat),
        .i_fill_data     (i_br_rd_data),
        .i_meta_index    (w_req_index),
        .o_meta_valid    (w_meta_valid),
        .o_meta_dirty    (w_meta_dirty),
        .o_meta_tag      (w_meta_tag),
        .i_meta_we       (w_meta_we),
        .i_meta_wr_index (w_meta_wr_index),
        .i_meta_valid    (w_meta_valid_in),
        .i_meta_dirty    (w_meta_dirty_in),
        .i_meta_tag      (w_meta_tag_in)
    );

    // Next state, store control and burst interface outputs
    always_comb begin
        w_state_nxt     = r_state;
        w_rd_en         = 1'b0;
        w_rd_index      = r_index;
        w_rd_beat       = r_beat;
        w_wr_en         = 1'b0;
        w_wr_index      = r_index;
        w_wr_col        = r_col;
        w_wr_mask       = r_wmask;
        w_wr_data       = r_wdata;
        w_fill_en       = 1'b0;
        w_meta_we       = 1'b0;
        w_meta_wr_index = r_index;
        w_meta_valid_in = 1'b1;
        w_meta_dirty_in = 1'b0;
        w_meta_tag_in   = r_tag;
        o_busy          = 1'b1;
        o_br_cmd        = BR_CMD_READ;
        o_br_cmd_en     = 1'b0;
        o_br_addr       = '0;
        o_br_wr_data    = '0;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (w_accept) begin
                    if (w_hit && w_is_write) begin
                        w_wr_en         = 1'b1;
                        w_wr_index      = w_req_index;
                        w_wr_col        = w_req_col;
                        w_wr_mask       = i_write_enable;
                        w_wr_data       = i_data_in;
                        w_meta_we       = 1'b1;
                        w_meta_wr_index = w_req_index;
                        w_meta_dirty_in = 1'b1;
                        w_meta_tag_in   = w_req_tag;
                    end else if (w_hit) begin
                        w_rd_en    = 1'b1;
                        w_rd_index = w_req_index;
                        w_rd_beat  = w_req_col[2:1];
                    end else if (w_meta_valid && w_meta_dirty) begin
                        // Prefetch victim beat 0 so it is on the bus with the command
                        w_rd_en     = 1'b1;
                        w_rd_index  = w_req_index;
                        w_rd_beat   = 2'd0;
                        w_state_nxt = ST_WB;
                    end else begin
                        w_state_nxt = ST_FILL_CMD;
                    end
                end
            end
            ST_WB: begin
                o_br_cmd     = BR_CMD_WRITE;
                o_br_cmd_en  = (r_beat == 2'd0);
                o_br_addr    = line_base(r_old_tag, r_index);
                o_br_wr_data = w_rd_data;
                w_rd_en      = 1'b1;
                w_rd_beat    = r_beat + 2'd1;
                if (r_beat == LAST_BEAT) begin
                    w_state_nxt = ST_FILL_CMD;
                end
            end
            ST_FILL_CMD: begin
                o_br_cmd_en = 1'b1;
                o_br_addr   = line_base(r_tag, r_index);
                w_state_nxt = ST_FILL;
            end
            ST_FILL: begin
                if (i_br_rd_data_valid) begin
                    w_fill_en = 1'b1;
                    if (r_beat == LAST_BEAT) begin
                        w_meta_we   = 1'b1;
                        w_state_nxt = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                if (r_wmask != 4'h0) begin
                    w_wr_en         = 1'b1;
                    w_meta_we       = 1'b1;
                    w_meta_dirty_in = 1'b1;
                end else begin
                    w_rd_en   = 1'b1;
                    w_rd_beat = r_col[2:1];
                end
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Beat counter shared by the write-back and fill bursts
    always_ff @(posedge i_clk) begin
        if (i_rst || r_state == ST_IDLE || r_state == ST_FILL_CMD) begin
            r_beat <= '0;
        end else if (r_state == ST_WB || (r_state == ST_FILL && i_br_rd_data_valid)) begin
            r_beat <= r_beat + 2'd1;
        end
    end

    // Latch every accepted request so a miss can be completed later
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_tag     <= w_req_tag;
            r_index   <= w_req_index;
            r_col     <= w_req_col;
            r_wdata   <= i_data_in;
            r_wmask   <= i_write_enable;
            r_old_tag <= w_meta_tag;
        end
    end

    // data_out_ready: set by a read hit or a completed read miss
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dout_rdy <= 1'b0;
        end else if (w_accept) begin
            r_dout_rdy <= w_hit && !w_is_write;
        end else if (r_state == ST_FINISH) begin
            r_dout_rdy <= (r_wmask == 4'h0);
        end
    end

endmodule

// File: tb/tb_psram_line_cache.sv
// Directed bench for psram_line_cache with a small 4-beat burst RAM model.
module tb_psram_line_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_init = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  write_enable = 4'h0;
    logic [31:0] address = 32'h0;
    logic [31:0] data_in = 32'h0;
    logic [31:0] data_out;
    logic        data_out_ready, busy, br_cmd, br_cmd_en;
    logic [3:0]  br_addr;
    logic [63:0] br_wr_data;
    logic [7:0]  br_data_mask;
    logic [63:0] br_rd_data;
    logic        br_rd_data_valid;

    int errors = 0;
    int checks = 0;

    logic [63:0] ram [16];
    int          rd_cyc;
    logic [3:0]  rd_base, wr_base, last_wr_addr, last_rd_addr;
    logic [1:0]  wr_beat;
    int          wr_cmds, rd_cmds;

    psram_line_cache #(
        .LineIndexBitWidth  (1),
        .RamAddressBitWidth (4),
        .RamAddressingMode  (3)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_enable           (enable),
        .i_write_enable     (write_enable),
        .i_address          (address),
        .i_data_in          (data_in),
        .o_data_out         (data_out),
        .o_data_out_ready   (data_out_ready),
        .o_busy             (busy),
        .o_br_cmd           (br_cmd),
        .o_br_cmd_en        (br_cmd_en),
        .o_br_addr          (br_addr),
        .o_br_wr_data       (br_wr_data),
        .o_br_data_mask     (br_data_mask),
        .i_br_rd_data       (br_rd_data),
        .i_br_rd_data_valid (br_rd_data_valid)
    );

    always #5 clk = ~clk;

    // Burst RAM model: write beats on the command cycle and the next three,
    // read beats returned after a fixed latency
    always @(posedge clk) begin
        br_rd_data_valid <= 1'b0;
        if (ram_init) begin
            for (int i = 0; i < 16; i++) ram[i] <= 64'h0;
            ram[1] <= 64'h9D8E2F17_AB4C3E6F;
            ram[2] <= 64'h00000000_D5B8A9C4;
            ram[3] <= 64'h7D4E9F2C_00000000;
            ram[4] <= 64'h00000000_2F5E3C7A;
            rd_cyc <= 0; wr_beat <= 2'd0; wr_cmds <= 0; rd_cmds <= 0;
            rd_base <= 4'h0; wr_base <= 4'h0; last_wr_addr <= 4'hF; last_rd_addr <= 4'hF;
            br_rd_data <= 64'h0;
        end else begin
            if (br_cmd_en && br_cmd) begin
                ram[br_addr] <= br_wr_data;
                wr_base <= br_addr; wr_beat <= 2'd1;
                last_wr_addr <= br_addr; wr_cmds <= wr_cmds + 1;
            end else if (wr_beat != 2'd0) begin
                ram[wr_base + {2'b00, wr_beat}] <= br_wr_data;
                wr_beat <= wr_beat + 2'd1;
            end
            if (br_cmd_en && !br_cmd) begin
                rd_base <= br_addr; rd_cyc <= 1;
                last_rd_addr <= br_addr; rd_cmds <= rd_cmds + 1;
            end else if (rd_cyc != 0) begin
                if (rd_cyc >= 5) begin
                    br_rd_data_valid <= 1'b1;
                    br_rd_data <= ram[rd_base + 4'(rd_cyc - 5)];
                end
                rd_cyc <= (rd_cyc == 8) ? 0 : rd_cyc + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] data);
        @(negedge clk);
        enable = 1'b1; address = addr; write_enable = we; data_in = data;
        @(posedge clk); #1;
        enable = 1'b0; write_enable = 4'h0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (4) @(posedge clk);
        @(negedge clk); ram_init = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_data_out", {32'd0, data_out}, 64'd0);
        chk("rst_dout_rdy", {63'd0, data_out_ready}, 64'd0);
        chk("rst_cmd_en", {63'd0, br_cmd_en}, 64'd0);
        chk("rst_cmd", {63'd0, br_cmd}, 64'd0);
        chk("rst_br_addr", {60'd0, br_addr}, 64'd0);
        chk("rst_wr_data", br_wr_data, 64'd0);
        chk("rst_mask", {56'd0, br_data_mask}, 64'd0);
        @(negedge clk); rst = 1'b0;

        // 1: cold miss then hit in the same line
        req(32'd16, 4'h0, 32'h0);
        chk("s1_busy_after_miss", {63'd0, busy}, 64'd1);
        chk("s1_rdy_low_miss", {63'd0, data_out_ready}, 64'd0);
        wait_idle("s1_wait");
        chk("s1_rdy", {63'd0, data_out_ready}, 64'd1);
        chk("s1_data16", {32'd0, data_out}, {32'd0, 32'hD5B8A9C4});
        chk("s1_fill_addr", {60'd0, last_rd_addr}, 64'd0);
        chk("s1_no_wb", 64'(wr_cmds), 64'd0);
        req(32'd8, 4'h0, 32'h0);
        chk("s1_hit_busy", {63'd0, busy}, 64'd0);
        chk("s1_hit_rdy", {63'd0, data_out_ready}, 64'd1);
        chk("s1_data8", {32'd0, data_out}, {32'd0, 32'hAB4C3E6F});

        // 2: miss on line 1, then hit on line 0
        req(32'd32, 4'h0, 32'h0);
        chk("s2_rdy_low", {63'd0, data_out_ready}, 64'd0);
        wait_idle("s2_wait");
        chk("s2_data32", {32'd0, data_out}, {32'd0, 32'h2F5E3C7A});
        chk("s2_fill_addr", {60'd0, last_rd_addr}, 64'd4);
        req(32'd12, 4'h0, 32'h0);
        chk("s2_data12", {32'd0, data_out}, {32'd0, 32'h9D8E2F17});

        // 3: byte-masked write hits
        req(32'd8, 4'b0001, 32'h000000AD);
        chk("s3_wr_busy", {63'd0, busy}, 64'd0);
        chk("s3_wr_rdy", {63'd0, data_out_ready}, 64'd0);
        req(32'd8, 4'h0, 32'h0);
        chk("s3_m0001", {32'd0, data_out}, {32'd0, 32'hAB4C3EAD});
        req(32'd8, 4'b0011, 32'h00008765);
        req(32'd8, 4'h0, 32'h0);
        chk("s3_m0011", {32'd0, data_out}, {32'd0, 32'hAB4C8765});
        req(32'd8, 4'b1100, 32'hFEEF0000);
        req(32'd8, 4'h0, 32'h0);
        chk("s3_m1100", {32'd0, data_out}, {32'd0, 32'hFEEF8765});

        // 4: write miss evicting dirty line 0
        req(32'd64, 4'b1111, 32'hABCDEF12);
        chk("s4_busy", {63'd0, busy}, 64'd1);
        wait_idle("s4_wait");
        chk("s4_wb_count", 64'(wr_cmds), 64'd1);
        chk("s4_wb_addr", {60'd0, last_wr_addr}, 64'd0);
        chk("s4_fill_addr", {60'd0, last_rd_addr}, 64'd8);
        chk("s4_ram1", ram[1], 64'h9D8E2F17_FEEF8765);
        req(32'd64, 4'h0, 32'h0);
        chk("s4_rd64", {32'd0, data_out}, {32'd0, 32'hABCDEF12});
        req(32'd64, 4'b1111, 32'h1B2D3F42);
        chk("s4_hit_busy", {63'd0, busy}, 64'd0);
        req(32'd64, 4'h0, 32'h0);
        chk("s4_rd64b", {32'd0, data_out}, {32'd0, 32'h1B2D3F42});

        // 5: write miss back to tag 0; reread the written-back word
        req(32'd0, 4'b1111, 32'h31323334);
        chk("s5_busy", {63'd0, busy}, 64'd1);
        wait_idle("s5_wait");
        chk("s5_wb_addr", {60'd0, last_wr_addr}, 64'd8);
        chk("s5_ram8", ram[8], 64'h00000000_1B2D3F42);
        req(32'd8, 4'h0, 32'h0);
        chk("s5_rd8", {32'd0, data_out}, {32'd0, 32'hFEEF8765});
        req(32'd0, 4'h0, 32'h0);
        chk("s5_rd0", {32'd0, data_out}, {32'd0, 32'h31323334});

        // 6: last column, then reset in the middle of a fill
        req(32'd28, 4'h0, 32'h0);
        chk("s6_rd28_busy", {63'd0, busy}, 64'd0);
        chk("s6_rd28", {32'd0, data_out}, {32'd0, 32'h7D4E9F2C});
        req(32'd96, 4'h0, 32'h0);
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("s6_rst_busy", {63'd0, busy}, 64'd0);
        chk("s6_rst_cmd_en", {63'd0, br_cmd_en}, 64'd0);
        chk("s6_rst_rdy", {63'd0, data_out_ready}, 64'd0);
        @(negedge clk); rst = 1'b0;
        repeat (20) @(posedge clk);
        req(32'd32, 4'h0, 32'h0);
        chk("s6_line1_invalid", {63'd0, busy}, 64'd1);
        wait_idle("s6_wait1");
        chk("s6_rd32", {32'd0, data_out}, {32'd0, 32'h2F5E3C7A});
        req(32'd8, 4'h0, 32'h0);
        chk("s6_line0_invalid", {63'd0, busy}, 64'd1);
        wait_idle("s6_wait0");
        chk("s6_rd8", {32'd0, data_out}, {32'd0, 32'hFEEF8765});
        chk("s6_no_extra_wb", 64'(wr_cmds), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
